// File: rtl/flow_key_extract.sv
// Single-pass parser for a 64-bit Ethernet receive stream: extracts the IPv4
// TCP/UDP 5-tuple key and flags for db_top, and counts frames, keys and drops.
module flow_key_extract #(
  parameter int          KEY_SIZE   = 96,
  parameter int          CNT_WIDTH  = 32,
  parameter logic [15:0] ETYPE_IPV4 = 16'h0800
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [63:0]          s_data,
  input  logic [7:0]           s_keep,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic [KEY_SIZE-1:0]  in_key,
  output logic [3:0]           in_flag,
  output logic                 in_valid,
  output logic [CNT_WIDTH-1:0] cnt_frame,
  output logic [CNT_WIDTH-1:0] cnt_key,
  output logic [CNT_WIDTH-1:0] cnt_drop
);

  typedef enum logic [2:0] {
    ST_RESYNC, ST_IDLE, ST_B1, ST_B2, ST_B3, ST_B4, ST_B5, ST_SKIP
  } state_t;

  state_t state, next_state;

  logic [7:0]  b [8];
  logic [31:0] src_ip;
  logic [15:0] dst_hi;
  logic [47:0] l4_tuple;   // {dst_ip[15:0], src_port, dst_port}
  logic        proto_tcp;

  logic [7:0]  need;
  logic        ok, complete, parse, bad, emit, fail;
  logic [KEY_SIZE-1:0] key_next;
  logic [3:0]          flag_next;

  always_comb begin
    for (int k = 0; k < 8; k++) b[k] = s_data[8*k +: 8];
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    need       = 8'h00;
    ok         = 1'b1;
    complete   = 1'b0;
    parse      = 1'b0;
    bad        = 1'b0;
    emit       = 1'b0;
    fail       = 1'b0;
    key_next   = {src_ip, dst_hi, l4_tuple};
    flag_next  = {b[7][0] | b[7][2], b[7][1], 1'b0, 1'b1};

    case (state)
      ST_RESYNC: if (s_valid && s_last) next_state = ST_IDLE;
      ST_IDLE:   parse = 1'b1;
      ST_B1: begin
        parse = 1'b1;
        need  = 8'b0111_0000;
        ok    = ({b[4], b[5]} == ETYPE_IPV4) && (b[6] == 8'h45);
      end
      ST_B2: begin
        parse = 1'b1;
        need  = 8'b1011_0000;
        ok    = ((b[7] == 8'd6) || (b[7] == 8'd17)) && ({b[4][4:0], b[5]} == 13'd0);
      end
      ST_B3: begin
        parse = 1'b1;
        need  = 8'b1111_1100;
      end
      ST_B4: begin
        parse     = 1'b1;
        need      = 8'b0011_1111;
        complete  = !proto_tcp;
        key_next  = {src_ip, dst_hi, b[0], b[1], b[2], b[3], b[4], b[5]};
        flag_next = 4'b0010;
      end
      ST_B5: begin
        parse    = 1'b1;
        need     = 8'b1000_0000;
        complete = 1'b1;
      end
      ST_SKIP:   if (s_valid && s_last) next_state = ST_IDLE;
      default:   next_state = ST_RESYNC;
    endcase

    if (parse && s_valid) begin
      // A runt is either a missing required byte or a frame ending before the key completes.
      bad = !ok || ((s_keep & need) != need) || (s_last && !complete);
      if (bad || complete) begin
        fail       = bad;
        emit       = !bad;
        next_state = s_last ? ST_IDLE : ST_SKIP;
      end else begin
        case (state)
          ST_IDLE: next_state = ST_B1;
          ST_B1:   next_state = ST_B2;
          ST_B2:   next_state = ST_B3;
          ST_B3:   next_state = ST_B4;
          default: next_state = ST_B5;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RESYNC;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ip    <= '0;
      dst_hi    <= '0;
      l4_tuple  <= '0;
      proto_tcp <= 1'b0;
    end else if (s_valid) begin
      if (state == ST_B2) proto_tcp <= (b[7] == 8'd6);
      if (state == ST_B3) begin
        src_ip <= {b[2], b[3], b[4], b[5]};
        dst_hi <= {b[6], b[7]};
      end
      if (state == ST_B4) l4_tuple <= {b[0], b[1], b[2], b[3], b[4], b[5]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_key    <= '0;
      in_flag   <= '0;
      in_valid  <= 1'b0;
      cnt_frame <= '0;
      cnt_key   <= '0;
      cnt_drop  <= '0;
    end else begin
      in_valid <= emit;
      if (emit) begin
        in_key  <= key_next;
        in_flag <= flag_next;
        cnt_key <= cnt_key + 1'b1;
      end
      if (fail) cnt_drop <= cnt_drop + 1'b1;
      if (s_valid && s_last && state != ST_RESYNC) cnt_frame <= cnt_frame + 1'b1;
    end
  end

endmodule
